// File: rtl/spi_q_defs.sv
// Shared definitions for the SPI command queue.
//   - sequencer state encoding
//   - bit positions inside the 8-bit status word
//   - field positions inside the 10-bit command word
//   - helper that packs the status word (level saturated to 3 bits)
package spi_q_defs;

  localparam int CMD_W        = 10;
  localparam int CMD_PWR_BIT  = 9;   // power-on word: driver never goes busy
  localparam int CMD_DC_BIT   = 8;   // data/command select
  localparam int CMD_BYTE_MSB = 7;   // byte occupies [7:0]

  localparam int ST_BUSY    = 7;
  localparam int ST_FULL    = 6;
  localparam int ST_EMPTY   = 5;
  localparam int ST_OVF     = 4;
  localparam int ST_ERR     = 3;
  localparam int ST_LVL_MSB = 2;     // level field occupies [2:0]

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_ACK  = 3'd2,
    S_XFER = 3'd3,
    S_GAPW = 3'd4
  } seq_state_e;

  // Builds the status word; the level field saturates at 7 for deep FIFOs.
  function automatic logic [7:0] pack_status(input logic busy, input logic full,
                                             input logic empty, input logic ovf,
                                             input logic err, input logic [6:0] lvl);
    logic [7:0] s;
    logic [2:0] sat;
    if (lvl > 7'd7) begin
      sat = 3'd7;
    end else begin
      sat = lvl[2:0];
    end
    s                 = 8'd0;
    s[ST_BUSY]        = busy;
    s[ST_FULL]        = full;
    s[ST_EMPTY]       = empty;
    s[ST_OVF]         = ovf;
    s[ST_ERR]         = err;
    s[ST_LVL_MSB:0]   = sat;
    return s;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO.
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   push, wdata     - write request and data (ignored while full)
//   pop             - read request (ignored while empty); rdata is the head
//   flush           - empties the FIFO; overrides push and pop
//   level           - registered occupancy
//   level_nxt       - occupancy after the current edge (for registered status)
//   full, empty     - decoded from level
module cmd_fifo
  import spi_q_defs::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = CMD_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic [LW-1:0]    level,
  output logic [LW-1:0]    level_nxt,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    count_r;
  logic [LW-1:0]    count_nxt_s;
  logic             push_acc_s;
  logic             pop_acc_s;

  assign full       = (count_r == LW'(DEPTH));
  assign empty      = (count_r == LW'(0));
  assign push_acc_s = push && !full && !flush;
  assign pop_acc_s  = pop && !empty && !flush;
  assign rdata      = mem_r[rd_ptr_r];
  assign level      = count_r;
  assign level_nxt  = count_nxt_s;

  // Next occupancy: flush clears, push+pop together leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = LW'(0);
    end else begin
      case ({push_acc_s, pop_acc_s})
        2'b10:   count_nxt_s = count_r + LW'(1);
        2'b01:   count_nxt_s = count_r - LW'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Pointer and occupancy registers; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= LW'(0);
    end else begin
      if (push_acc_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_acc_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  // Storage array; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push_acc_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/spi_cmd_queue.sv
// SPI command queue: buffers CPU command words and issues them one at a time
// to an external SPI driver, with handshake timeout and inter-word gap.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   wr, wdata   - CPU write strobe and 10-bit command word
//   clr         - flush FIFO and clear sticky ovf/err (sequencer keeps running)
//   status      - registered {busy, full, empty, ovf, err, level[2:0]}
//   level       - exact FIFO occupancy
//   spi_start   - registered one-cycle start pulse
//   spi_din     - registered word, held until the next issue
//   spi_busy    - driver busy, high from START until STOP completes
module spi_cmd_queue
  import spi_q_defs::*;
#(
  parameter int DEPTH  = 16,
  parameter int GAP    = 2,
  parameter int ACK_TO = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [CMD_W-1:0]         wdata,
  input  logic                     clr,
  output logic [7:0]               status,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     spi_start,
  output logic [CMD_W-1:0]         spi_din,
  input  logic                     spi_busy
);

  localparam int LW = $clog2(DEPTH) + 1;

  seq_state_e        state_r;
  seq_state_e        state_nxt_s;
  logic [15:0]       cnt_r;
  logic [15:0]       cnt_nxt_s;
  logic              issue_s;
  logic              err_set_s;
  logic              ovf_r;
  logic              ovf_nxt_s;
  logic              err_r;
  logic              err_nxt_s;
  logic              busy_nxt_s;
  logic              start_r;
  logic [CMD_W-1:0]  din_r;
  logic [7:0]        status_r;
  logic [CMD_W-1:0]  head_s;
  logic [LW-1:0]     level_s;
  logic [LW-1:0]     level_nxt_s;
  logic              full_s;
  logic              empty_s;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr),
    .wdata     (wdata),
    .pop       (issue_s),
    .flush     (clr),
    .rdata     (head_s),
    .level     (level_s),
    .level_nxt (level_nxt_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Sequencer next-state logic; cnt is shared by the ACK timeout and the gap.
  // Issue is held off during clr so a word being flushed is never sent.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    issue_s     = 1'b0;
    err_set_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!empty_s && !spi_busy && !clr) begin
          issue_s     = 1'b1;
          state_nxt_s = S_SEND;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_SEND: begin
        cnt_nxt_s = 16'd0;
        if (din_r[CMD_PWR_BIT]) begin
          state_nxt_s = S_GAPW;   // power-on word never raises spi_busy
        end else begin
          state_nxt_s = S_ACK;
        end
      end
      S_ACK: begin
        if (spi_busy) begin
          state_nxt_s = S_XFER;
        end else if (cnt_r == 16'(ACK_TO - 1)) begin
          state_nxt_s = S_GAPW;
          err_set_s   = 1'b1;
          cnt_nxt_s   = 16'd0;
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      S_XFER: begin
        if (!spi_busy) begin
          state_nxt_s = S_GAPW;
          cnt_nxt_s   = 16'd0;
        end else begin
          state_nxt_s = S_XFER;
        end
      end
      S_GAPW: begin
        if (cnt_r == 16'(GAP - 1)) begin
          state_nxt_s = S_IDLE;
          cnt_nxt_s   = 16'd0;
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = 16'd0;
      end
    endcase
  end

  // Sticky flags; clr wins, and a write while full counts even with a pop.
  always_comb begin
    ovf_nxt_s = ovf_r;
    err_nxt_s = err_r;
    if (clr) begin
      ovf_nxt_s = 1'b0;
      err_nxt_s = 1'b0;
    end else begin
      if (wr && full_s) begin
        ovf_nxt_s = 1'b1;
      end else begin
        ovf_nxt_s = ovf_r;
      end
      if (err_set_s) begin
        err_nxt_s = 1'b1;
      end else begin
        err_nxt_s = err_r;
      end
    end
    busy_nxt_s = (state_nxt_s != S_IDLE) || (level_nxt_s != LW'(0));
  end

  // State, flags and outputs; status is built from next values so it
  // describes the same cycle as level and the sequencer state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= S_IDLE;
      cnt_r    <= 16'd0;
      ovf_r    <= 1'b0;
      err_r    <= 1'b0;
      start_r  <= 1'b0;
      din_r    <= CMD_W'(0);
      status_r <= 8'b0010_0000;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      ovf_r    <= ovf_nxt_s;
      err_r    <= err_nxt_s;
      start_r  <= issue_s;
      if (issue_s) begin
        din_r <= head_s;
      end
      status_r <= pack_status(busy_nxt_s, level_nxt_s == LW'(DEPTH),
                              level_nxt_s == LW'(0), ovf_nxt_s, err_nxt_s,
                              7'(level_nxt_s));
    end
  end

  assign spi_start = start_r;
  assign spi_din   = din_r;
  assign status    = status_r;
  assign level     = level_s;

endmodule

// File: tb/tb_spi_cmd_queue.sv
module tb_spi_cmd_queue;

  logic       clk;
  logic       reset;
  logic       wr;
  logic [9:0] wdata;
  logic       clr;
  logic [7:0] status;
  logic [4:0] level;
  logic       spi_start;
  logic [9:0] spi_din;
  logic       spi_busy;

  spi_cmd_queue #(.DEPTH(16), .GAP(2), .ACK_TO(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .wdata     (wdata),
    .clr       (clr),
    .status    (status),
    .level     (level),
    .spi_start (spi_start),
    .spi_din   (spi_din),
    .spi_busy  (spi_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [9:0] wdata;
    logic       clr;
    logic [4:0] exp_level;
    logic [7:0] exp_status;
  } vec_t;

  vec_t       vecs[10];
  logic [9:0] exp_q[$];
  int checks;
  int failures;
  int cyc;
  int nstarts;
  int last_start;
  int prev_start;
  int drv_en;
  int drv_cnt;
  int drv_len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock; scoreboard every start pulse; optional driver busy model.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (spi_start) begin
      prev_start = last_start;
      last_start = cyc;
      nstarts++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra_start actual=%0h required=none", spi_din);
      end else begin
        chk("sb_din", {22'd0, spi_din}, {22'd0, exp_q.pop_front()});
      end
      if (drv_en != 0 && !spi_din[9]) drv_cnt = drv_len;
    end
    if (drv_en != 0) begin
      if (drv_cnt > 0) begin
        spi_busy = 1'b1;
        drv_cnt--;
      end else begin
        spi_busy = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (status[7] && n < budget) begin
      tick();
      n++;
    end
    chk(name, {31'd0, status[7]}, 32'd0);
  endtask

  task automatic wait_start(input int budget, input string name);
    int n;
    int ns0;
    n = 0;
    ns0 = nstarts;
    while (nstarts == ns0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, nstarts - ns0, 1);
  endtask

  initial begin
    int t0;
    int ns0;
    int c;
    checks = 0; failures = 0; cyc = 0; nstarts = 0;
    last_start = 0; prev_start = 0; drv_en = 0; drv_cnt = 0; drv_len = 3;
    reset = 1'b1; wr = 1'b0; wdata = 10'd0; clr = 1'b0; spi_busy = 1'b0;

    vecs[0] = '{1'b1, 10'h011, 1'b0, 5'd1, 8'h81};
    vecs[1] = '{1'b1, 10'h022, 1'b0, 5'd2, 8'h82};
    vecs[2] = '{1'b0, 10'h000, 1'b0, 5'd2, 8'h82};
    vecs[3] = '{1'b1, 10'h3FF, 1'b1, 5'd0, 8'h20};
    vecs[4] = '{1'b1, 10'h033, 1'b0, 5'd1, 8'h81};
    vecs[5] = '{1'b1, 10'h144, 1'b0, 5'd2, 8'h82};
    vecs[6] = '{1'b1, 10'h055, 1'b0, 5'd3, 8'h83};
    vecs[7] = '{1'b0, 10'h000, 1'b1, 5'd0, 8'h20};
    vecs[8] = '{1'b1, 10'h066, 1'b0, 5'd1, 8'h81};
    vecs[9] = '{1'b1, 10'h077, 1'b0, 5'd2, 8'h82};

    // Reset state
    tick(); tick();
    chk("rst_status", {24'd0, status}, 32'h20);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_start", {31'd0, spi_start}, 32'd0);
    chk("rst_din", {22'd0, spi_din}, 32'd0);
    reset = 1'b0;

    // Table: FIFO fill/clear with the driver held busy (nothing issues)
    spi_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr = vecs[i].wr; wdata = vecs[i].wdata; clr = vecs[i].clr;
      if (vecs[i].clr) exp_q.delete();
      else if (vecs[i].wr) exp_q.push_back(vecs[i].wdata);
      tick();
      chk($sformatf("vec%0d_level", i), {27'd0, level}, {27'd0, vecs[i].exp_level});
      chk($sformatf("vec%0d_status", i), {24'd0, status}, {24'd0, vecs[i].exp_status});
    end
    wr = 1'b0; clr = 1'b0;
    spi_busy = 1'b0; drv_en = 1;
    ns0 = nstarts;
    wait_idle(100, "tbl_drain_idle");
    chk("tbl_drain_count", nstarts - ns0, 2);
    chk("tbl_drain_status", {24'd0, status}, 32'h20);

    // Latency and long busy hold
    drv_en = 0; spi_busy = 1'b0;
    t0 = cyc;
    wr = 1'b1; wdata = 10'h03A; exp_q.push_back(10'h03A);
    tick(); wr = 1'b0;
    tick();
    chk("lat_start", {31'd0, spi_start}, 32'd1);
    chk("lat_cycle", last_start - t0, 2);
    ns0 = nstarts;
    tick(); spi_busy = 1'b1;
    tick(); wr = 1'b1; wdata = 10'h0C3; exp_q.push_back(10'h0C3);
    tick(); wr = 1'b0;
    while (cyc - t0 < 453) tick();
    chk("no_start_in_busy", nstarts - ns0, 0);
    spi_busy = 1'b0; drv_en = 1;
    wait_start(20, "gap_start_seen");
    chk("gap_start_cyc", last_start - t0, 457);
    wait_idle(50, "lat_idle");
    chk("lat_status", {24'd0, status}, 32'h20);

    // Overflow: 17 writes while busy
    drv_en = 0; spi_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr = 1'b1; wdata = 10'h040 + 10'(i);
      if (i < 16) exp_q.push_back(10'h040 + 10'(i));
      tick();
    end
    wr = 1'b0;
    chk("ovf_level", {27'd0, level}, 32'd16);
    chk("ovf_status", {24'd0, status}, 32'hD7);
    spi_busy = 1'b0; drv_en = 1;
    ns0 = nstarts;
    wait_idle(400, "ovf_drain_idle");
    chk("ovf_drain_count", nstarts - ns0, 16);
    chk("ovf_q_empty", exp_q.size(), 0);
    chk("ovf_sticky", {24'd0, status}, 32'h30);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("ovf_clr", {24'd0, status}, 32'h20);

    // Power-on word skips the handshake
    wr = 1'b1; wdata = 10'h200; exp_q.push_back(10'h200);
    tick();
    wdata = 10'h155; exp_q.push_back(10'h155);
    tick(); wr = 1'b0;
    wait_idle(60, "pwr_idle");
    chk("pwr_spacing", last_start - prev_start, 4);
    chk("pwr_no_err", {24'd0, status}, 32'h20);

    // Handshake timeout
    drv_en = 0; spi_busy = 1'b0;
    wr = 1'b1; wdata = 10'h0FF; exp_q.push_back(10'h0FF);
    tick(); wr = 1'b0;
    wait_start(10, "to_start");
    c = cyc;
    while (cyc - c < 4) tick();
    chk("to_ack_last", {24'd0, status}, 32'hA0);
    tick();
    chk("to_err_set", {24'd0, status}, 32'hA8);
    tick(); tick();
    chk("to_idle", {24'd0, status}, 32'h28);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("to_clr", {24'd0, status}, 32'h20);

    // wr and clr together with 5 words queued
    spi_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; wdata = 10'h0A0 + 10'(i); exp_q.push_back(10'h0A0 + 10'(i));
      tick();
    end
    wr = 1'b1; clr = 1'b1; wdata = 10'h2AA; exp_q.delete();
    tick(); wr = 1'b0; clr = 1'b0;
    chk("wrclr_level", {27'd0, level}, 32'd0);
    chk("wrclr_status", {24'd0, status}, 32'h20);
    spi_busy = 1'b0; drv_en = 1;
    ns0 = nstarts;
    for (int i = 0; i < 20; i++) tick();
    chk("wrclr_no_start", nstarts - ns0, 0);

    // Reset during XFER with 3 words queued
    drv_en = 0; spi_busy = 1'b0;
    wr = 1'b1; wdata = 10'h011; exp_q.push_back(10'h011); tick();
    wdata = 10'h022; exp_q.push_back(10'h022); tick();
    wdata = 10'h033; exp_q.push_back(10'h033); tick();
    wdata = 10'h044; exp_q.push_back(10'h044); tick();
    wr = 1'b0; spi_busy = 1'b1;
    tick(); tick();
    chk("xfer_level", {27'd0, level}, 32'd3);
    chk("xfer_din", {22'd0, spi_din}, 32'h011);
    reset = 1'b1;
    tick();
    chk("mid_rst_status", {24'd0, status}, 32'h20);
    chk("mid_rst_start", {31'd0, spi_start}, 32'd0);
    chk("mid_rst_din", {22'd0, spi_din}, 32'd0);
    chk("mid_rst_level", {27'd0, level}, 32'd0);
    reset = 1'b0; spi_busy = 1'b0; exp_q.delete();
    ns0 = nstarts;
    for (int i = 0; i < 5; i++) tick();
    chk("post_rst_quiet", nstarts - ns0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
